// File: rtl/pipe_ctrl_hazard.sv
// Control and hazard unit for a 5-stage RV32I pipeline: instruction decode, E/M/W
// control registers, branch resolution, and stall/flush/forwarding selects.
module pipe_ctrl_hazard #(
  parameter bit FWD_EN   = 1'b1,
  parameter bit ZERO_CHK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic        ZeroE,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  output logic [1:0]  ImmSrcD,
  output logic        ALUSrcE,
  output logic [2:0]  ALUControlE,
  output logic        MemWriteM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic        PCSrcE,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef struct packed {
    logic       regWrite;
    logic [1:0] resultSrc;
    logic       memWrite;
    logic       jump;
    logic       branch;
    logic       aluSrc;
    logic [2:0] aluControl;
  } ctrl_t;

  logic [6:0] opD;
  logic [2:0] funct3D;
  logic       funct7b5D;
  logic [1:0] aluOpD;
  ctrl_t      ctrlD;
  ctrl_t      ctrlE;
  logic       regWriteM;
  logic [1:0] resultSrcM;
  logic       stall;
  logic       unusedInstrBits;

  assign opD             = InstrD[6:0];
  assign funct3D         = InstrD[14:12];
  assign funct7b5D       = InstrD[30];
  assign unusedInstrBits = ^{InstrD[31], InstrD[29:15], InstrD[11:7]};

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    ctrlD   = '0;
    ImmSrcD = 2'b00;
    aluOpD  = 2'b00;
    case (opD)
      OP_LW:  begin ctrlD.regWrite = 1'b1; ctrlD.resultSrc = 2'b01; ctrlD.aluSrc = 1'b1; end
      OP_SW:  begin ctrlD.memWrite = 1'b1; ctrlD.aluSrc = 1'b1; ImmSrcD = 2'b01; end
      OP_R:   begin ctrlD.regWrite = 1'b1; aluOpD = 2'b10; end
      OP_I:   begin ctrlD.regWrite = 1'b1; ctrlD.aluSrc = 1'b1; aluOpD = 2'b10; end
      OP_BEQ: begin ctrlD.branch = 1'b1; ImmSrcD = 2'b10; aluOpD = 2'b01; end
      OP_JAL: begin ctrlD.regWrite = 1'b1; ctrlD.resultSrc = 2'b10; ctrlD.jump = 1'b1; ImmSrcD = 2'b11; end
      default: ;
    endcase
    case (aluOpD)
      2'b01: ctrlD.aluControl = 3'b001;
      2'b10: begin
        case (funct3D)
          3'b000:  ctrlD.aluControl = (opD == OP_R && funct7b5D) ? 3'b001 : 3'b000;
          3'b010:  ctrlD.aluControl = 3'b101;
          3'b110:  ctrlD.aluControl = 3'b011;
          3'b111:  ctrlD.aluControl = 3'b010;
          default: ctrlD.aluControl = 3'b000;
        endcase
      end
      default: ctrlD.aluControl = 3'b000;
    endcase
  end

  function automatic logic regHit(input logic [4:0] rs, input logic [4:0] rd, input logic wr);
    return wr && (rs == rd) && (!ZERO_CHK || (rs != 5'd0));
  endfunction

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (FWD_EN) begin
      if (regHit(Rs1E, RdM, regWriteM))      ForwardAE = 2'b10;
      else if (regHit(Rs1E, RdW, RegWriteW)) ForwardAE = 2'b01;
      if (regHit(Rs2E, RdM, regWriteM))      ForwardBE = 2'b10;
      else if (regHit(Rs2E, RdW, RegWriteW)) ForwardBE = 2'b01;
    end
  end

  // Without bypassing, W needs no check because the regfile writes on the falling edge.
  always_comb begin
    if (FWD_EN)
      stall = (ctrlE.resultSrc == 2'b01) && ((Rs1D == RdE) || (Rs2D == RdE)) &&
              ((RdE != 5'd0) || !ZERO_CHK);
    else
      stall = regHit(Rs1D, RdE, ctrlE.regWrite) || regHit(Rs2D, RdE, ctrlE.regWrite) ||
              regHit(Rs1D, RdM, regWriteM)      || regHit(Rs2D, RdM, regWriteM);
  end

  assign PCSrcE      = (ctrlE.branch & ZeroE) | ctrlE.jump;
  assign StallF      = stall;
  assign StallD      = stall;
  assign FlushD      = PCSrcE;
  assign FlushE      = PCSrcE | stall;
  assign ALUSrcE     = ctrlE.aluSrc;
  assign ALUControlE = ctrlE.aluControl;

  // NOTE: state uses non-blocking assignments so every register loads its pre-edge input.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlE      <= '0;
      regWriteM  <= 1'b0;
      resultSrcM <= 2'b00;
      MemWriteM  <= 1'b0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
    end else begin
      if (FlushE) ctrlE <= '0;
      else        ctrlE <= ctrlD;
      regWriteM  <= ctrlE.regWrite;
      resultSrcM <= ctrlE.resultSrc;
      MemWriteM  <= ctrlE.memWrite;
      RegWriteW  <= regWriteM;
      ResultSrcW <= resultSrcM;
    end
  end
endmodule
